// File: rtl/viterbi_seq_control.sv
// Viterbi decoder trellis sequencer: INIT -> RECURSE -> TERM -> TRACEBACK -> DONE.
// Optional run-length counter on output run_cycles when VITERBI_CYCLE_CNT_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start; indices parked at 0
// INIT      | pi x emission per hidden state, obs 0
// RECURSE   | ACS over every (obs 1..NUM_OBS-1, state) pair
// TERM      | single argmax step on the last observation
// TRACEBACK | walk obs NUM_OBS-1 down to 1, state index held at 0
// DONE      | one-cycle completion pulse, then back to IDLE
module viterbi_seq_control #(
  parameter int NUM_OBS    = 11,
  parameter int NUM_STATES = 4,
  parameter int OBS_W      = 4,
  parameter int ST_W       = 2
) (
  input  logic             clk,
  input  logic             reset_viterbi_seq_control,
  input  logic             start,
  input  logic             stall,
  output logic [OBS_W-1:0] obs_idx,
  output logic [ST_W-1:0]  state_idx,
  output logic             init_en,
  output logic             acs_en,
  output logic             term_en,
  output logic             tb_en,
  output logic             busy,
  output logic             done
`ifdef VITERBI_CYCLE_CNT_EN
  ,
  output logic [15:0]      run_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_RECURSE, S_TERM, S_TRACEBACK, S_DONE
  } state_t;

  localparam logic [OBS_W-1:0] LAST_OBS = OBS_W'(NUM_OBS - 1);
  localparam logic [ST_W-1:0]  LAST_ST  = ST_W'(NUM_STATES - 1);

  state_t state;

  // Enables are registered against the step being presented next; a stalled
  // edge holds every index and presents that same step with no enable.
  always_ff @(posedge clk or negedge reset_viterbi_seq_control) begin
    if (!reset_viterbi_seq_control) begin
      state     <= S_IDLE;
      obs_idx   <= '0;
      state_idx <= '0;
      init_en   <= 1'b0;
      acs_en    <= 1'b0;
      term_en   <= 1'b0;
      tb_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      init_en <= 1'b0;
      acs_en  <= 1'b0;
      term_en <= 1'b0;
      tb_en   <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_INIT;
            obs_idx   <= '0;
            state_idx <= '0;
            init_en   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_INIT: begin
          if (!stall) begin
            if (state_idx == LAST_ST) begin
              state     <= S_RECURSE;
              obs_idx   <= OBS_W'(1);
              state_idx <= '0;
              acs_en    <= 1'b1;
            end else begin
              state_idx <= state_idx + ST_W'(1);
              init_en   <= 1'b1;
            end
          end
        end
        S_RECURSE: begin
          if (!stall) begin
            if (state_idx != LAST_ST) begin
              state_idx <= state_idx + ST_W'(1);
              acs_en    <= 1'b1;
            end else if (obs_idx == LAST_OBS) begin
              state     <= S_TERM;
              state_idx <= '0;
              term_en   <= 1'b1;
            end else begin
              obs_idx   <= obs_idx + OBS_W'(1);
              state_idx <= '0;
              acs_en    <= 1'b1;
            end
          end
        end
        S_TERM: begin
          if (!stall) begin
            state <= S_TRACEBACK;
            tb_en <= 1'b1;
          end
        end
        S_TRACEBACK: begin
          if (!stall) begin
            if (obs_idx == OBS_W'(1)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              obs_idx <= obs_idx - OBS_W'(1);
              tb_en   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          obs_idx   <= '0;
          state_idx <= '0;
          busy      <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          obs_idx   <= '0;
          state_idx <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef VITERBI_CYCLE_CNT_EN
  // Counts every active cycle including stalls; DONE and IDLE do not count.
  always_ff @(posedge clk or negedge reset_viterbi_seq_control) begin
    if (!reset_viterbi_seq_control) begin
      run_cycles <= '0;
    end else if (state == S_IDLE && start) begin
      run_cycles <= '0;
    end else if (state != S_IDLE && state != S_DONE && run_cycles != 16'hFFFF) begin
      run_cycles <= run_cycles + 16'd1;
    end
  end
`endif

endmodule
